// File: rtl/btn_debounce.sv
// btn_debounce: per-button two-flop synchronizer and debounce counter, sticky
// press/release events, one Wishbone register and a level interrupt.
//
// Register (single address):
//   [NBTN-1:0]  debounced levels (read only)
//   [8+k]       press[k]  (write 1 to clear)
//   [16+k]      rel[k]    (write 1 to clear)
//   [24+k]      en[k]     (read/write interrupt enable)

// One button: synchronize, debounce, and flag accepted level changes.
module btn_debounce_lane #(
    parameter int unsigned DEBOUNCE = 100000,
    parameter int          CW       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          accept;

    // The change is taken on the DEBOUNCE-th consecutive differing sample.
    assign accept = (sync != level) && (cnt == LAST);
    assign rise   = accept & sync;
    assign fall   = accept & ~sync;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Count consecutive mismatching samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= sync;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module btn_debounce #(
    parameter int          NBTN     = 2,
    parameter int unsigned DEBOUNCE = 100000,
    parameter int          CW       = 20
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NBTN-1:0] i_btn_raw,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    output logic [NBTN-1:0] o_btn,
    output logic            o_int
);
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic [NBTN-1:0] en;
    logic [NBTN-1:0] clr_press;
    logic [NBTN-1:0] clr_rel;
    logic            wr;
    logic [31:0]     rd_val;

    // The cycle line carries no information beyond the strobe, and the low
    // data byte plus unpopulated button slots are write-ignored.
    logic unused;
    assign unused = ^{i_wb_cyc, i_wb_data};

    btn_debounce_lane #(
        .DEBOUNCE(DEBOUNCE),
        .CW      (CW)
    ) u_lane [NBTN-1:0] (
        .clk  (i_clk),
        .rst_n(i_reset_n),
        .raw  (i_btn_raw),
        .level(o_btn),
        .rise (rise),
        .fall (fall)
    );

    assign wr        = i_wb_stb & i_wb_we;
    assign clr_press = wr ? i_wb_data[8 +: NBTN]  : '0;
    assign clr_rel   = wr ? i_wb_data[16 +: NBTN] : '0;

    // Sticky events; a new event on the clearing cycle keeps the bit set.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            press <= '0;
            rel   <= '0;
            en    <= '0;
        end else begin
            press <= (press & ~clr_press) | rise;
            rel   <= (rel & ~clr_rel) | fall;
            if (wr) en <= i_wb_data[24 +: NBTN];
        end
    end

    // Read view of the register; unpopulated slots stay zero.
    always_comb begin
        rd_val               = '0;
        rd_val[NBTN-1:0]     = o_btn;
        rd_val[8 +: NBTN]    = press;
        rd_val[16 +: NBTN]   = rel;
        rd_val[24 +: NBTN]   = en;
    end

    // Zero-wait bus: ack every strobe next cycle with the pre-write state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) o_wb_data <= rd_val;
        end
    end

    // Registered interrupt from any enabled pending event.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_int <= 1'b0;
        else            o_int <= |(en & (press | rel));
    end
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE=4, NBTN=2: directed scenarios with
// constant expectations plus a randomized run against a window-based model.
module tb_btn_debounce;
    localparam int NB = 2;
    localparam int D  = 4;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] raw   = '0;
    logic          cyc   = 1'b0;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic [31:0]   wdata = '0;
    logic          ack;
    logic [31:0]   rdata;
    logic [NB-1:0] btn;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    btn_debounce #(.NBTN(NB), .DEBOUNCE(D), .CW(CW)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_btn_raw(raw),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_we  (we),
        .i_wb_data(wdata),
        .o_wb_ack (ack),
        .o_wb_data(rdata),
        .o_btn    (btn),
        .o_int    (irq)
    );

    // Reference model: a level flips when the last D synchronized samples
    // all disagree with it.
    logic [NB-1:0]         m_s1, m_s2, m_btn, m_press, m_rel, m_en, m_flip;
    logic [NB-1:0][D-1:0]  m_hist, m_newh;
    logic                  m_int, m_ack;
    logic [31:0]           m_rd;

    function automatic logic [31:0] m_regs();
        return {8'(m_en), 8'(m_rel), 8'(m_press), 8'(m_btn)};
    endfunction

    always_comb begin
        m_flip = '0;
        m_newh = '0;
        for (int k = 0; k < NB; k++) begin
            m_newh[k] = {m_hist[k][D-2:0], m_s2[k]};
            m_flip[k] = (m_newh[k] == {D{~m_btn[k]}});
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_hist <= '0; m_btn <= '0;
            m_press <= '0; m_rel <= '0; m_en <= '0;
            m_int <= 1'b0; m_ack <= 1'b0; m_rd <= '0;
        end else begin
            m_s1    <= raw;
            m_s2    <= m_s1;
            m_hist  <= m_newh;
            m_btn   <= m_btn ^ m_flip;
            m_press <= (m_press & ~((stb && we) ? wdata[8 +: NB] : '0)) | (m_flip & ~m_btn);
            m_rel   <= (m_rel & ~((stb && we) ? wdata[16 +: NB] : '0)) | (m_flip & m_btn);
            if (stb && we) m_en <= wdata[24 +: NB];
            m_int   <= |(m_en & (m_press | m_rel));
            m_ack   <= stb;
            if (stb) m_rd <= m_regs();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; raw = '0; stb = 1'b0; we = 1'b0; wdata = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wb_write(input logic [31:0] d);
        stb = 1'b1; we = 1'b1; wdata = d;
        tick();
        stb = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic wb_read(output logic [31:0] d, output logic a);
        stb = 1'b1; we = 1'b0;
        tick();
        d = rdata; a = ack;
        stb = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        a;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raw = NB'($urandom);
            tick();
            n_cmp++;
            if (btn !== '0 || irq !== 1'b0 || ack !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: btn=%b int=%b ack=%b want 0/0/0", btn, irq, ack);
            end
        end
        raw = '0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_idle_ack: got %b want 0", ack); end
        wb_read(d, a);
        n_cmp++;
        if (a !== 1'b1 || d !== 32'h0) begin
            n_bad++; $display("FAIL reset_read: ack=%b data=%h want 1/00000000", a, d);
        end
        tick();
        n_cmp++;
        if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack_drop: got %b want 0", ack); end
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        logic        a;
        do_reset();
        tick();
        raw[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (btn[0] !== (i == 6)) begin
                n_bad++; $display("FAIL press_latency: cycle %0d btn0=%b want %b", i, btn[0], (i == 6));
            end
        end
        wb_read(d, a);
        n_cmp++;
        if (d !== 32'h0000_0101 || irq !== 1'b0) begin
            n_bad++; $display("FAIL press_read: data=%h int=%b want 00000101/0", d, irq);
        end
    endtask

    task automatic test_bounce();
        int          seg [4] = '{3, 2, 3, 8};
        logic [31:0] d;
        logic        a;
        do_reset();
        tick();
        for (int s = 0; s < 4; s++) begin
            raw[1] = (s % 2 == 0) && (s < 3);
            for (int i = 0; i < seg[s]; i++) begin
                tick();
                n_cmp++;
                if (btn !== '0) begin n_bad++; $display("FAIL bounce_level: btn=%b want 00", btn); end
            end
        end
        wb_read(d, a);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL bounce_read: data=%h want 00000000", d); end
    endtask

    task automatic test_release_int();
        logic [31:0] d;
        logic        a;
        do_reset();
        wb_write(32'h0300_0000);
        raw[1] = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (btn[1] !== 1'b1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL int_rise_pre: btn1=%b int=%b want 1/0", btn[1], irq);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL int_rise: got %b want 1", irq); end
        raw[1] = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (btn[1] !== 1'b0) begin n_bad++; $display("FAIL release_level: got %b want 0", btn[1]); end
        wb_read(d, a);
        n_cmp++;
        if (d !== 32'h0302_0200) begin n_bad++; $display("FAIL release_read: data=%h want 03020200", d); end
        wb_write(32'h0302_0200);
        n_cmp++;
        if (irq !== 1'b1 || ack !== 1'b1) begin
            n_bad++; $display("FAIL clear_edge: int=%b ack=%b want 1/1", irq, ack);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL int_drop: got %b want 0", irq); end
        wb_read(d, a);
        n_cmp++;
        if (d !== 32'h0300_0000) begin n_bad++; $display("FAIL cleared_read: data=%h want 03000000", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic        a;
        do_reset();
        tick();
        raw[0] = 1'b1;
        repeat (5) tick();
        wb_write(32'h0000_0100);
        n_cmp++;
        if (btn[0] !== 1'b1) begin n_bad++; $display("FAIL collide_level: got %b want 1", btn[0]); end
        wb_read(d, a);
        n_cmp++;
        if (d !== 32'h0000_0101) begin n_bad++; $display("FAIL collide_read: data=%h want 00000101", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3] = '{32'h0, 32'h0100_0000, 32'h0100_0000};
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            stb = 1'b1; we = (i == 0); wdata = (i == 0) ? 32'h0100_0000 : 32'h0;
            tick();
            n_cmp++;
            if (ack !== 1'b1 || rdata !== want[i]) begin
                n_bad++; $display("FAIL b2b_%0d: ack=%b data=%h want 1/%h", i, ack, rdata, want[i]);
            end
        end
        stb = 1'b0; we = 1'b0; wdata = '0;
        tick();
        n_cmp++;
        if (ack !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: ack=%b want 0", ack); end
    endtask

    task automatic test_async_mid();
        do_reset();
        tick();
        raw[0] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (btn !== '0) begin n_bad++; $display("FAIL midreset_async: btn=%b want 00", btn); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (btn[0] !== (i == 6)) begin
                n_bad++; $display("FAIL midreset_latency: cycle %0d btn0=%b want %b", i, btn[0], (i == 6));
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (hold == 0) begin
                raw  = NB'($urandom);
                hold = $urandom_range(1, 2 * D + 2);
            end
            hold--;
            r     = $urandom_range(0, 9);
            stb   = (r < 3);
            we    = (r == 0);
            wdata = $urandom;
            tick();
            n_cmp++;
            if (btn !== m_btn || irq !== m_int || ack !== m_ack || rdata !== m_rd) begin
                n_bad++;
                $display("FAIL random_c%0d: btn=%b int=%b ack=%b data=%h want %b/%b/%b/%h",
                         c, btn, irq, ack, rdata, m_btn, m_int, m_ack, m_rd);
            end
        end
        stb = 1'b0; we = 1'b0; wdata = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_int();
        test_collision();
        test_back_to_back();
        test_async_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
